matrix_loader: RTL and testbench

Upstream feeder for the 3x3 matrix multiplier. It accepts a byte stream on `Ain` under a valid/ready handshake and assembles the 18 operand elements, A row-major first and then B row-major, into registered outputs that drive the multiplier's A00..A22 and B00..B22 inputs. When all 18 are captured it pulses `Load` for one cycle, then holds the operands stable until the multiplier reports `Done`.

---
 rtl/matrix_loader.sv | 162 ++++++++++++++++
 tb/tb_matrix_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//   Upstream feeder for the 3x3 matrix multiplier. Collects 18 stream elements
//   (A row-major, then B row-major) over a valid/ready handshake into registered
//   operand outputs, pulses Load for one cycle, then holds the operands until
//   the multiplier reports Done.
//
// Ports:
//   clk        in   clock, rising-edge
//   Reset      in   asynchronous active-low reset
//   Ain        in   WIDTH  stream element
//   Ain_valid  in   Ain holds a valid element
//   Ain_ready  out  loader can accept an element (state-only, low in reset)
//   Clear      in   synchronous flush of the current collection
//   Done       in   completion flag from the multiplier
//   A00..A22   out  WIDTH  A operands, row-major
//   B00..B22   out  WIDTH  B operands, row-major
//   Load       out  one-cycle start pulse
//   Count      out  5  elements accepted in the current collection (0..18)
//   Err        out  sticky timeout flag
//
// Optional feature: define MATRIX_LOADER_TIMEOUT_EN to enable the WAIT-state
// timeout (TIMEOUT cycles) and the sticky Err flag. Without it Err is 0.
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Ain,
  input  logic             Ain_valid,
  output logic             Ain_ready,
  input  logic             Clear,
  input  logic             Done,
  output logic [WIDTH-1:0] A00, A01, A02, A10, A11, A12, A20, A21, A22,
  output logic [WIDTH-1:0] B00, B01, B02, B10, B11, B12, B20, B21, B22,
  output logic             Load,
  output logic [4:0]       Count,
  output logic             Err
);

  typedef enum logic [1:0] {ST_COLLECT, ST_FIRE, ST_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_op [0:17];
  logic [4:0]       r_count;
  logic             w_xfer;
  logic             w_timeout;

  // Clear drops any element offered in the same cycle.
  assign w_xfer = Ain_valid & Ain_ready & ~Clear;

`ifdef MATRIX_LOADER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_err;

  // Done sampled on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == ST_WAIT) && !Done && (r_wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_err <= 1'b0;
    end else if (Clear) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  // Timeout disabled: constant-false for any legal TIMEOUT.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_xfer && (r_count == 5'd17)) w_next = ST_FIRE;
      ST_FIRE:    w_next = ST_WAIT;
      ST_WAIT:    if (Done || w_timeout) w_next = ST_COLLECT;
      default:    w_next = ST_COLLECT;
    endcase
    if (Clear) w_next = ST_COLLECT;
  end

  // Outputs decoded from the state register only
  always_comb begin
    Ain_ready = Reset && (r_state == ST_COLLECT);
    Load      = (r_state == ST_FIRE);
`ifdef MATRIX_LOADER_TIMEOUT_EN
    Err       = r_err;
`else
    Err       = 1'b0;
`endif
  end

  // Element counter: cleared on Clear or on leaving WAIT (Done / timeout).
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= 5'd0;
    end else if (Clear || ((r_state == ST_WAIT) && (w_next == ST_COLLECT))) begin
      r_count <= 5'd0;
    end else if (w_xfer) begin
      r_count <= r_count + 5'd1;
    end
  end

  // Operand registers: only Reset clears them; a transfer writes slot Count.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 18; i++) r_op[i] <= '0;
    end else if (w_xfer) begin
      r_op[r_count] <= Ain;
    end
  end

  assign Count = r_count;

  assign A00 = r_op[0];
  assign A01 = r_op[1];
  assign A02 = r_op[2];
  assign A10 = r_op[3];
  assign A11 = r_op[4];
  assign A12 = r_op[5];
  assign A20 = r_op[6];
  assign A21 = r_op[7];
  assign A22 = r_op[8];
  assign B00 = r_op[9];
  assign B01 = r_op[10];
  assign B02 = r_op[11];
  assign B10 = r_op[12];
  assign B11 = r_op[13];
  assign B12 = r_op[14];
  assign B20 = r_op[15];
  assign B21 = r_op[16];
  assign B22 = r_op[17];

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
//   Directed bench for matrix_loader: reset, back-to-back stream, gapped valid,
//   Done handshake with frozen operands, Clear mid-collection, Clear+Done in
//   WAIT, asynchronous reset in WAIT, and (when MATRIX_LOADER_TIMEOUT_EN is
//   defined) the WAIT timeout with sticky Err.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Ain;
  logic       Ain_valid;
  logic       Ain_ready;
  logic       Clear;
  logic       Done;
  logic [7:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
  logic [7:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;
  logic       Load;
  logic [4:0] Count;
  logic       Err;

  logic [7:0] ops [0:17];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_load   = 0;
  int         base;

  always #5 clk = ~clk;

  matrix_loader #(.WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .Reset(Reset), .Ain(Ain), .Ain_valid(Ain_valid),
    .Ain_ready(Ain_ready), .Clear(Clear), .Done(Done),
    .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12),
    .A20(A20), .A21(A21), .A22(A22),
    .B00(B00), .B01(B01), .B02(B02), .B10(B10), .B11(B11), .B12(B12),
    .B20(B20), .B21(B21), .B22(B22),
    .Load(Load), .Count(Count), .Err(Err)
  );

  assign ops[0]  = A00;  assign ops[1]  = A01;  assign ops[2]  = A02;
  assign ops[3]  = A10;  assign ops[4]  = A11;  assign ops[5]  = A12;
  assign ops[6]  = A20;  assign ops[7]  = A21;  assign ops[8]  = A22;
  assign ops[9]  = B00;  assign ops[10] = B01;  assign ops[11] = B02;
  assign ops[12] = B10;  assign ops[13] = B11;  assign ops[14] = B12;
  assign ops[15] = B20;  assign ops[16] = B21;  assign ops[17] = B22;

  // Load pulses seen at rising edges
  always @(posedge clk) if (Load) n_load <= n_load + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b0; Ain = 8'h00; Ain_valid = 1'b0; Clear = 1'b0; Done = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_count", 32'(Count), 32'd0);
    check("rst_load",  32'(Load), 32'd0);
    check("rst_err",   32'(Err), 32'd0);
    check("rst_ready", 32'(Ain_ready), 32'd0);
    check("rst_A00",   32'(A00), 32'd0);
    check("rst_B22",   32'(B22), 32'd0);
    Reset = 1'b1;
    #1;
    check("ready_after_rst", 32'(Ain_ready), 32'd1);

    // Back-to-back stream: 9 x 0x20 then 9 x 0x28
    base = n_load;
    for (int i = 0; i < 18; i++) begin
      Ain = (i < 9) ? 8'h20 : 8'h28;
      Ain_valid = 1'b1;
      tick();
    end
    Ain_valid = 1'b0;
    check("s1_load_fire",  32'(Load), 32'd1);
    check("s1_count",      32'(Count), 32'd18);
    check("s1_ready_fire", 32'(Ain_ready), 32'd0);
    for (int i = 0; i < 18; i++)
      check($sformatf("s1_op%0d", i), 32'(ops[i]), (i < 9) ? 32'h20 : 32'h28);
    tick();
    check("s1_load_wait",  32'(Load), 32'd0);
    check("s1_ready_wait", 32'(Ain_ready), 32'd0);
    check("s1_nload",      32'(n_load - base), 32'd1);

    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("s1_done_ready", 32'(Ain_ready), 32'd1);
    check("s1_done_count", 32'(Count), 32'd0);

    // Gapped valid: 0x01..0x12, valid every other cycle
    base = n_load;
    for (int i = 1; i <= 17; i++) begin
      Ain = 8'(i); Ain_valid = 1'b1;
      tick();
      Ain = 8'hEE; Ain_valid = 1'b0;
      tick();
    end
    Ain = 8'h12; Ain_valid = 1'b1;
    tick();
    Ain_valid = 1'b0;
    check("s2_load_fire", 32'(Load), 32'd1);
    check("s2_count",     32'(Count), 32'd18);
    tick();
    check("s2_A00", 32'(A00), 32'h01);
    check("s2_A22", 32'(A22), 32'h09);
    check("s2_B00", 32'(B00), 32'h0A);
    check("s2_B22", 32'(B22), 32'h12);
    check("s2_nload", 32'(n_load - base), 32'd1);

    // Done handshake: 10 cycles waiting with valid offered, operands frozen
    Ain = 8'h99; Ain_valid = 1'b1;
    repeat (10) tick();
    check("s3_wait_load",  32'(Load), 32'd0);
    check("s3_wait_ready", 32'(Ain_ready), 32'd0);
    check("s3_wait_A00",   32'(A00), 32'h01);
    check("s3_wait_B22",   32'(B22), 32'h12);
    check("s3_wait_nload", 32'(n_load - base), 32'd1);
    check("s3_wait_count", 32'(Count), 32'd18);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("s3_ready", 32'(Ain_ready), 32'd1);
    check("s3_count", 32'(Count), 32'd0);
    check("s3_A00_kept", 32'(A00), 32'h01);
    Ain = 8'h55;
    tick();
    Ain_valid = 1'b0;
    check("s3_A00", 32'(A00), 32'h55);
    check("s3_A01", 32'(A01), 32'h02);
    check("s3_B22", 32'(B22), 32'h12);
    check("s3_count1", 32'(Count), 32'd1);

    // Clear mid-collection after 7 transfers, concurrent with valid 0x77
    Ain_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      Ain = 8'(8'h60 + k);
      tick();
    end
    check("s4_count7", 32'(Count), 32'd7);
    Ain = 8'h77; Clear = 1'b1;
    tick();
    Clear = 1'b0; Ain_valid = 1'b0;
    check("s4_clr_count", 32'(Count), 32'd0);
    check("s4_clr_A21",   32'(A21), 32'h08);
    check("s4_clr_A10",   32'(A10), 32'h63);
    check("s4_clr_ready", 32'(Ain_ready), 32'd1);
    base = n_load;
    for (int i = 0; i < 18; i++) begin
      Ain = 8'(8'h80 + i); Ain_valid = 1'b1;
      tick();
    end
    Ain_valid = 1'b0;
    check("s4_load_fire", 32'(Load), 32'd1);
    tick();
    check("s4_A00",   32'(A00), 32'h80);
    check("s4_A21",   32'(A21), 32'h87);
    check("s4_B22",   32'(B22), 32'h91);
    check("s4_count", 32'(Count), 32'd18);
    check("s4_nload", 32'(n_load - base), 32'd1);

    // Clear and Done on the same WAIT edge
    Clear = 1'b1; Done = 1'b1;
    tick();
    Clear = 1'b0; Done = 1'b0;
    check("s5_count", 32'(Count), 32'd0);
    check("s5_ready", 32'(Ain_ready), 32'd1);
    check("s5_A00",   32'(A00), 32'h80);

    // Asynchronous reset while in WAIT
    for (int i = 0; i < 18; i++) begin
      Ain = 8'h33; Ain_valid = 1'b1;
      tick();
    end
    Ain_valid = 1'b0;
    tick();
    check("s6_wait_ready", 32'(Ain_ready), 32'd0);
    check("s6_wait_A00",   32'(A00), 32'h33);
    #2;
    Reset = 1'b0;
    #1;
    check("s6_A00",   32'(A00), 32'd0);
    check("s6_B22",   32'(B22), 32'd0);
    check("s6_count", 32'(Count), 32'd0);
    check("s6_load",  32'(Load), 32'd0);
    check("s6_err",   32'(Err), 32'd0);
    check("s6_ready", 32'(Ain_ready), 32'd0);

`ifdef MATRIX_LOADER_TIMEOUT_EN
    // Timeout: complete a load, never assert Done
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      Ain = 8'h44; Ain_valid = 1'b1;
      tick();
    end
    Ain_valid = 1'b0;
    tick();
    repeat (63) tick();
    check("to_err_early",   32'(Err), 32'd0);
    check("to_ready_early", 32'(Ain_ready), 32'd0);
    tick();
    check("to_err",   32'(Err), 32'd1);
    check("to_ready", 32'(Ain_ready), 32'd1);
    check("to_count", 32'(Count), 32'd0);
    repeat (3) tick();
    check("to_err_sticky", 32'(Err), 32'd1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("to_err_clr", 32'(Err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
